load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sequential load/store engine between the execute stage and data memory.
- Accepts one memory request at a time, decodes the target region (CPU BRAM or MMIO registers), drives registered BRAM port signals, and waits out the BRAM read latency.
- Read words return through the memory output stage; this block then applies little-endian lane extraction and sign/zero extension, and issues a one-cycle response.

Parameters:
- MEM_DISABLE, 2'b00, op: no access.
- MEM_READ_SEXT, 2'b01, op: sign-extended load.
- MEM_READ_ZEXT, 2'b10, op: zero-extended load.
- MEM_WRITE, 2'b11, op: store.
- BYTE / HALFWORD / WORD, 2'b00 / 2'b01 / 2'b10, size codes.
- BRAM_END, 32'h007F_FF00, exclusive upper byte address of CPU BRAM (base is 0).
- READ_REG_INPUT, 32'h0200_0000, MMIO input register address (read-only).
- WRITE_REG_OUTPUT, 32'h0200_0100, MMIO output register address (write-only).
- READ_LATENCY, 1, BRAM read latency in cycles (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- addr  in  32  byte address.
- mem_op  in  2  operation code.
- mem_size  in  2  access size.
- wdata  in  32  store data (LSB-aligned).
- bram_en  out  1  BRAM enable (registered).
- bram_we  out  4  byte write enables; bit i = byte lane i.
- bram_addr  out  32  word-aligned byte address (bits [1:0] = 0).
- bram_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  read word from the memory output stage.
- reg_input  in  32  external input register value.
- reg_output  out  32  MMIO output register.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  load result; 0 for stores, disables, and faults.
- fault  out  1  valid only with resp_valid; set for an invalid region, size, or direction.

Behaviour:

Reset:
- Asynchronous; state forced to IDLE.
- All outputs driven to 0 except req_ready, which is 1. reg_output = 0.
- Reset mid-transaction abandons the request with no response.

States: IDLE, ISSUE, WAIT, RESP.
- IDLE: capture addr, op, size, and wdata on accept (cycle N), then go to ISSUE.
- ISSUE (N+1):
  - If the access is a BRAM access: drive bram_en for exactly this cycle, with bram_we and bram_wdata set (we = 0 for reads).
  - If the access is an MMIO write: update reg_output.
  - If the access is an MMIO read: sample reg_input.
  - Then go to WAIT if the access is a BRAM read, otherwise to RESP.
- WAIT: count READ_LATENCY cycles, then capture mem_rdata and go to RESP.
- RESP: resp_valid = 1 for one cycle, then go to IDLE.

Latency:
- Stores, MMIO accesses, disables, and faults: resp_valid at N+2.
- BRAM loads: resp_valid at N+2+READ_LATENCY (N+3 by default).
- Back-to-back: the next accept is possible in the cycle after RESP.

Decode:
- CPU BRAM: addr < BRAM_END.
- MMIO: exact match on READ_REG_INPUT or WRITE_REG_OUTPUT.
- Any other address, a read of WRITE_REG_OUTPUT, a write of READ_REG_INPUT, or mem_size = 2'b11 → fault, with no BRAM or register side effect.
- MEM_DISABLE: no side effect, fault = 0, resp_data = 0.
- MMIO accesses are word-only; the size field is ignored for them.

Store steering:
- BYTE: wdata[7:0] replicated to all 4 lanes; we = 1 << addr[1:0].
- HALFWORD: wdata[15:0] replicated to both halves; we = 4'b0011 when addr[1] = 0, else 4'b1100.
- WORD: we = 4'b1111.

Load extraction:
- Lane k = mem_rdata[8k+7:8k].
- BYTE selects lane addr[1:0]; HALFWORD selects lanes {addr[1],1}:{addr[1],0}.
- Result is sign- or zero-extended per op.

Alignment (without the optional feature): addr[0] is ignored for HALFWORD; addr[1:0] are ignored for WORD.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined: a HALFWORD access with addr[0] = 1, or a WORD access with addr[1:0] ≠ 0, yields fault at N+2, with no BRAM access and resp_data = 0.
- When undefined: low address bits are silently masked as described above, and fault never results from alignment.

Test Plan:
- Store WORD 0xDEADBEEF to 0x10: bram_we = 1111 and bram_addr = 0x10 at N+1. Then load WORD from 0x10 with mem_rdata = 0xDEADBEEF: resp_data = 0xDEADBEEF at N+3, fault = 0.
- SEXT BYTE load from 0x13 with mem_rdata = 0x80112233 → resp_data = 0xFFFFFF80. The same load with ZEXT → 0x00000080.
- Store HALFWORD 0x1234 to 0x22 → bram_we = 1100, bram_wdata = 0x12341234. SEXT HALFWORD load from 0x22 with mem_rdata = 0x9ABC0000 → 0xFFFF9ABC.
- Write 0x55 to 0x0200_0100 → reg_output = 0x55 at N+1 and resp at N+2. Read 0x0200_0000 with reg_input = 0xA5A5 → resp_data = 0x0000A5A5. Read of 0x0200_0100 → fault = 1.
- Load from 0x0300_0000 → fault = 1 at N+2, bram_en never asserted. Assert reset during WAIT → immediate IDLE, reg_output = 0, no resp_valid.
- WORD load from 0x06: with MISALIGN_TRAP_EN → fault = 1 and no bram_en; without it → bram_addr = 0x04 and a normal response.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store engine between execute and data memory.
// Decodes CPU BRAM vs MMIO, drives registered BRAM port signals,
// waits out the BRAM read latency, and extracts/extends loaded data.
// Optional build macro: MISALIGN_TRAP_EN (fault on misaligned HALFWORD/WORD BRAM accesses).
//
// state  | meaning
// IDLE   | ready for a request; BRAM/MMIO-write side effects launched on accept
// ISSUE  | BRAM enable high this cycle; MMIO input sampled
// WAIT   | counting down the BRAM read latency
// RESP   | one-cycle response pulse
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [1:0]  mem_op,
    input  logic [1:0]  mem_size,
    input  logic [31:0] wdata,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] reg_input,
    output logic [31:0] reg_output,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        fault
);

    localparam logic [1:0]  MEM_DISABLE      = 2'b00;
    localparam logic [1:0]  MEM_READ_SEXT    = 2'b01;
    localparam logic [1:0]  MEM_READ_ZEXT    = 2'b10;
    localparam logic [1:0]  MEM_WRITE        = 2'b11;
    localparam logic [1:0]  BYTE             = 2'b00;
    localparam logic [1:0]  HALFWORD         = 2'b01;
    localparam logic [1:0]  WORD             = 2'b10;
    localparam logic [31:0] BRAM_END         = 32'h007F_FF00;
    localparam logic [31:0] READ_REG_INPUT   = 32'h0200_0000;
    localparam logic [31:0] WRITE_REG_OUTPUT = 32'h0200_0100;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [2:0] {K_NONE, K_FAULT, K_BRAM_RD, K_BRAM_WR, K_MMIO_RD, K_MMIO_WR} kind_t;

    state_t      state;
    kind_t       kind_q;
    kind_t       kind_c;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [7:0]  wait_cnt;
    logic        misalign;
    logic [3:0]  we_c;
    logic [31:0] wdata_c;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    // Region/direction decode of the incoming request
    always_comb begin
        kind_c   = K_FAULT;
`ifdef MISALIGN_TRAP_EN
        misalign = ((mem_size == HALFWORD) && addr[0]) ||
                   ((mem_size == WORD) && (addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        if (mem_op == MEM_DISABLE) begin
            kind_c = K_NONE;
        end else if (mem_size == 2'b11) begin
            kind_c = K_FAULT;
        end else if (addr < BRAM_END) begin
            if (misalign)
                kind_c = K_FAULT;
            else if (mem_op == MEM_WRITE)
                kind_c = K_BRAM_WR;
            else
                kind_c = K_BRAM_RD;
        end else if ((addr == READ_REG_INPUT) &&
                     ((mem_op == MEM_READ_SEXT) || (mem_op == MEM_READ_ZEXT))) begin
            kind_c = K_MMIO_RD;
        end else if ((addr == WRITE_REG_OUTPUT) && (mem_op == MEM_WRITE)) begin
            kind_c = K_MMIO_WR;
        end
    end

    // Store lane steering: byte enables and replicated write data
    always_comb begin
        we_c    = 4'b1111;
        wdata_c = wdata;
        case (mem_size)
            BYTE: begin
                we_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            HALFWORD: begin
                we_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            WORD: begin
                we_c    = 4'b1111;
                wdata_c = wdata;
            end
            default: begin
                we_c    = 4'b0000;
                wdata_c = 32'h0;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        case (lo_q)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            BYTE:     load_data = {{24{sext_q & lane_b[7]}}, lane_b};
            HALFWORD: load_data = {{16{sext_q & lane_h[15]}}, lane_h};
            default:  load_data = mem_rdata;
        endcase
    end

    // Sequencer with registered BRAM, MMIO and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            kind_q     <= K_NONE;
            lo_q       <= 2'b00;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            wait_cnt   <= 8'd0;
            req_ready  <= 1'b1;
            bram_en    <= 1'b0;
            bram_we    <= 4'b0000;
            bram_addr  <= 32'h0;
            bram_wdata <= 32'h0;
            reg_output <= 32'h0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            fault      <= 1'b0;
        end else begin
            bram_en    <= 1'b0;
            bram_we    <= 4'b0000;
            bram_addr  <= 32'h0;
            bram_wdata <= 32'h0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        kind_q    <= kind_c;
                        lo_q      <= addr[1:0];
                        size_q    <= mem_size;
                        sext_q    <= (mem_op == MEM_READ_SEXT);
                        state     <= S_ISSUE;
                        if ((kind_c == K_BRAM_RD) || (kind_c == K_BRAM_WR)) begin
                            bram_en   <= 1'b1;
                            bram_addr <= {addr[31:2], 2'b00};
                        end
                        if (kind_c == K_BRAM_WR) begin
                            bram_we    <= we_c;
                            bram_wdata <= wdata_c;
                        end
                        if (kind_c == K_MMIO_WR)
                            reg_output <= wdata;
                    end
                end
                S_ISSUE: begin
                    if (kind_q == K_BRAM_RD) begin
                        wait_cnt <= 8'(READ_LATENCY - 1);
                        state    <= S_WAIT;
                    end else begin
                        resp_valid <= 1'b1;
                        fault      <= (kind_q == K_FAULT);
                        resp_data  <= (kind_q == K_MMIO_RD) ? reg_input : 32'h0;
                        state      <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        resp_valid <= 1'b1;
                        fault      <= 1'b0;
                        resp_data  <= load_data;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    fault      <= 1'b0;
                    resp_data  <= 32'h0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests, a
// cycle-indexed expectation model, and literal pins on key results.
module tb_load_store_unit;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] addr = '0;
    logic [1:0]  mem_op = '0;
    logic [1:0]  mem_size = '0;
    logic [31:0] wdata = '0;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] reg_input = '0;
    logic [31:0] reg_output;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        bit          flt;
        logic [31:0] data;
        bit          bram;
        logic [3:0]  we;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        bit          regwr;
        int          lat;
    } exp_t;

    exp_t        rv_at[int];
    exp_t        en_at[int];
    bit          busy_at[int];
    logic [31:0] regchg[int];
    logic [31:0] model_reg = '0;

    logic [31:0] last_data, last_baddr, last_bwdata;
    logic [3:0]  last_we;
    logic        last_fault;
    int          en_count = 0;
    int          resp_count = 0;

    load_store_unit #(.READ_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .mem_op(mem_op), .mem_size(mem_size), .wdata(wdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .mem_rdata(mem_rdata), .reg_input(reg_input),
        .reg_output(reg_output), .resp_valid(resp_valid), .resp_data(resp_data),
        .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural expectation from the access rules (sizes as byte counts)
    function automatic exp_t model(input logic [1:0] op, input logic [1:0] sz,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, input logic [31:0] rin);
        exp_t        e;
        int          bytes;
        int          start;
        logic [31:0] v;
        logic [31:0] mask;
        e = '{flt: 1'b0, data: 32'h0, bram: 1'b0, we: 4'h0, baddr: 32'h0,
              bwdata: 32'h0, regwr: 1'b0, lat: 2};
        if (op == 2'b00) return e;
        if (sz == 2'b11) begin
            e.flt = 1'b1;
            return e;
        end
        bytes = 1 << sz;
        start = int'(a[1:0]) & ~(bytes - 1);
        if (a < 32'h007F_FF00) begin
`ifdef MISALIGN_TRAP_EN
            if ((int'(a[1:0]) % bytes) != 0) begin
                e.flt = 1'b1;
                return e;
            end
`endif
            e.bram  = 1'b1;
            e.baddr = a - 32'(a[1:0]);
            if (op == 2'b11) begin
                e.we = 4'(((1 << bytes) - 1) << start);
                for (int i = 0; i < 4; i++)
                    e.bwdata[8*i +: 8] = wd[8*(i % bytes) +: 8];
            end else begin
                v = rd >> (8 * start);
                if (bytes < 4) begin
                    mask = (32'd1 << (8 * bytes)) - 32'd1;
                    v = v & mask;
                    if (op == 2'b01 && v[8*bytes-1]) v = v | ~mask;
                end
                e.data = v;
                e.lat  = 2 + LAT;
            end
        end else if (a == 32'h0200_0000 && op != 2'b11) begin
            e.data = rin;
        end else if (a == 32'h0200_0100 && op == 2'b11) begin
            e.regwr = 1'b1;
        end else begin
            e.flt = 1'b1;
        end
        return e;
    endfunction

    // Per-cycle comparison of every output against the scheduled model
    always @(negedge clk) begin
        if (reset) begin
            model_reg = '0;
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_bram_en", 32'(bram_en), 32'd0);
            chk("rst_bram_we", 32'(bram_we), 32'd0);
            chk("rst_reg_output", reg_output, 32'h0);
            chk("rst_resp_data", resp_data, 32'h0);
            chk("rst_fault", 32'(fault), 32'd0);
        end else begin
            if (regchg.exists(cyc)) model_reg = regchg[cyc];
            chk("reg_output", reg_output, model_reg);
            chk("req_ready", 32'(req_ready), busy_at.exists(cyc) ? 32'd0 : 32'd1);
            chk("resp_valid", 32'(resp_valid), rv_at.exists(cyc) ? 32'd1 : 32'd0);
            if (resp_valid && rv_at.exists(cyc)) begin
                chk("resp_data", resp_data, rv_at[cyc].data);
                chk("fault", 32'(fault), 32'(rv_at[cyc].flt));
            end
            if (resp_valid) begin
                last_data  = resp_data;
                last_fault = fault;
                resp_count++;
            end
            chk("bram_en", 32'(bram_en), en_at.exists(cyc) ? 32'd1 : 32'd0);
            if (bram_en && en_at.exists(cyc)) begin
                chk("bram_we", 32'(bram_we), 32'(en_at[cyc].we));
                chk("bram_addr", bram_addr, en_at[cyc].baddr);
                chk("bram_wdata", bram_wdata, en_at[cyc].bwdata);
            end
            if (bram_en) begin
                last_we     = bram_we;
                last_baddr  = bram_addr;
                last_bwdata = bram_wdata;
                en_count++;
            end
        end
    end

    // Drive one request in the current (idle) cycle and schedule its effects
    task automatic start_req(input logic [1:0] op, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input logic [31:0] rin,
                             output int r_cyc);
        exp_t e;
        int   n;
        n = cyc;
        e = model(op, sz, a, wd, rd, rin);
        mem_op = op; mem_size = sz; addr = a; wdata = wd;
        mem_rdata = rd; reg_input = rin;
        req_valid = 1'b1;
        if (e.bram) en_at[n+1] = e;
        if (e.regwr) regchg[n+1] = wd;
        r_cyc = n + e.lat;
        rv_at[r_cyc] = e;
        for (int k = n + 1; k <= r_cyc; k++) busy_at[k] = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [31:0] rin);
        int r;
        start_req(op, sz, a, wd, rd, rin, r);
        while (cyc <= r) @(negedge clk);
    endtask

    task automatic lit_resp(input string nm, input logic [31:0] d, input logic f);
        chk({nm, "_data"}, last_data, d);
        chk({nm, "_fault"}, 32'(last_fault), 32'(f));
    endtask

    int r_tmp;
    int en_before;
    int resp_before;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready_lit", 32'(req_ready), 32'd1);
        chk("reset_regout_lit", reg_output, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // WORD store then WORD load
        do_req(2'b11, 2'b10, 32'h10, 32'hDEAD_BEEF, 32'h0, 32'h0);
        chk("st_word_we", 32'(last_we), 32'hF);
        chk("st_word_addr", last_baddr, 32'h10);
        lit_resp("st_word", 32'h0, 1'b0);
        do_req(2'b01, 2'b10, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0);
        lit_resp("ld_word", 32'hDEAD_BEEF, 1'b0);

        // Byte loads, sign and zero extended
        do_req(2'b01, 2'b00, 32'h13, 32'h0, 32'h8011_2233, 32'h0);
        lit_resp("ld_sb", 32'hFFFF_FF80, 1'b0);
        do_req(2'b10, 2'b00, 32'h13, 32'h0, 32'h8011_2233, 32'h0);
        lit_resp("ld_zb", 32'h0000_0080, 1'b0);
        do_req(2'b01, 2'b00, 32'h11, 32'h0, 32'h8011_2233, 32'h0);
        lit_resp("ld_sb_lane1", 32'h0000_0022, 1'b0);

        // Halfword store / loads
        do_req(2'b11, 2'b01, 32'h22, 32'h0000_1234, 32'h0, 32'h0);
        chk("st_half_we", 32'(last_we), 32'hC);
        chk("st_half_wdata", last_bwdata, 32'h1234_1234);
        do_req(2'b01, 2'b01, 32'h22, 32'h0, 32'h9ABC_0000, 32'h0);
        lit_resp("ld_sh", 32'hFFFF_9ABC, 1'b0);
        do_req(2'b10, 2'b01, 32'h20, 32'h0, 32'h9ABC_8001, 32'h0);
        lit_resp("ld_zh", 32'h0000_8001, 1'b0);

        // Byte store steering
        do_req(2'b11, 2'b00, 32'h01, 32'h0000_00AB, 32'h0, 32'h0);
        chk("st_byte_we", 32'(last_we), 32'h2);
        chk("st_byte_wdata", last_bwdata, 32'hABAB_ABAB);

        // MMIO write, read, wrong-direction accesses
        start_req(2'b11, 2'b10, 32'h0200_0100, 32'h55, 32'h0, 32'h0, r_tmp);
        chk("mmio_wr_n1", reg_output, 32'h55);
        while (cyc <= r_tmp) @(negedge clk);
        lit_resp("mmio_wr", 32'h0, 1'b0);
        do_req(2'b10, 2'b10, 32'h0200_0000, 32'h0, 32'h0, 32'h0000_A5A5);
        lit_resp("mmio_rd", 32'h0000_A5A5, 1'b0);
        do_req(2'b01, 2'b10, 32'h0200_0100, 32'h0, 32'h0, 32'h0);
        lit_resp("mmio_rd_out", 32'h0, 1'b1);
        do_req(2'b11, 2'b10, 32'h0200_0000, 32'h77, 32'h0, 32'h0);
        lit_resp("mmio_wr_in", 32'h0, 1'b1);
        chk("mmio_wr_in_noeffect", reg_output, 32'h55);

        // Unmapped region, BRAM boundary, bad size, disable
        en_before = en_count;
        do_req(2'b01, 2'b10, 32'h0300_0000, 32'h0, 32'h1234_5678, 32'h0);
        lit_resp("unmapped", 32'h0, 1'b1);
        chk("unmapped_no_en", 32'(en_count - en_before), 32'd0);
        do_req(2'b10, 2'b10, 32'h007F_FEFC, 32'h0, 32'hCAFE_F00D, 32'h0);
        lit_resp("bram_last", 32'hCAFE_F00D, 1'b0);
        do_req(2'b10, 2'b10, 32'h007F_FF00, 32'h0, 32'hCAFE_F00D, 32'h0);
        lit_resp("bram_end", 32'h0, 1'b1);
        do_req(2'b01, 2'b11, 32'h40, 32'h0, 32'hFFFF_FFFF, 32'h0);
        lit_resp("size3", 32'h0, 1'b1);
        do_req(2'b00, 2'b10, 32'h44, 32'h9999_9999, 32'hFFFF_FFFF, 32'h0);
        lit_resp("disable", 32'h0, 1'b0);

        // Misaligned WORD load
        en_before = en_count;
        do_req(2'b10, 2'b10, 32'h06, 32'h0, 32'h1122_3344, 32'h0);
`ifdef MISALIGN_TRAP_EN
        lit_resp("misalign", 32'h0, 1'b1);
        chk("misalign_no_en", 32'(en_count - en_before), 32'd0);
`else
        lit_resp("misalign", 32'h1122_3344, 1'b0);
        chk("misalign_addr", last_baddr, 32'h04);
`endif

        // Reset asserted while waiting for BRAM read data
        resp_before = resp_count;
        start_req(2'b01, 2'b10, 32'h30, 32'h0, 32'h8765_4321, 32'h0, r_tmp);
        @(negedge clk);
        #1 reset = 1'b1;
        rv_at.delete(); en_at.delete(); busy_at.delete(); regchg.delete();
        @(negedge clk);
        chk("rst_wait_regout", reg_output, 32'h0);
        chk("rst_wait_ready", 32'(req_ready), 32'd1);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wait_no_resp", 32'(resp_count - resp_before), 32'd0);

        // Normal operation after the abort
        do_req(2'b10, 2'b01, 32'h32, 32'h0, 32'hF00D_1234, 32'h0);
        lit_resp("post_rst", 32'h0000_F00D, 1'b0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
